// File: rtl/pe_feeder_pkg.sv
// ---------------------------------------------------------------------------
// pe_feeder_pkg
// Shared constants for the PE input feeder: FSM state encoding, the position
// of the row flags above the packed data lanes, and the skid buffer depth.
// ---------------------------------------------------------------------------
package pe_feeder_pkg;

  // Plain 2-bit state constants keep the encoding stable for older tooling
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t LOAD  = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t DONE  = 2'd3;

  // Flag offsets, counted from the first bit above the data lanes
  localparam int EOR_BIT = 0;
  localparam int SOR_BIT = 1;

  // Words a stream may hold between its memory and the PE FIFO
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/pe_input_feeder_if.sv
// ---------------------------------------------------------------------------
// pe_input_feeder_if
// Push-side bus between the feeder and the PE input FIFOs.
//   ready_ifm / ready_fil     : FIFO can accept a word this cycle
//   w_en_ifm / w_en_fil       : push strobe
//   data_in_ifm               : packed lanes + end-of-row + start-of-row
//   data_in_fil               : packed filter lanes
// master = feeder, slave = PE.
// ---------------------------------------------------------------------------
interface pe_input_feeder_if
  import pe_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_WRITE  = 2
);
  localparam int WW = DATA_WIDTH * PAR_WRITE;

  logic          ready_ifm;
  logic          w_en_ifm;
  logic [WW+1:0] data_in_ifm;
  logic          ready_fil;
  logic          w_en_fil;
  logic [WW-1:0] data_in_fil;

  modport master (
    input  ready_ifm, ready_fil,
    output w_en_ifm, data_in_ifm, w_en_fil, data_in_fil
  );

  modport slave (
    output ready_ifm, ready_fil,
    input  w_en_ifm, data_in_ifm, w_en_fil, data_in_fil
  );
endinterface

// File: rtl/pe_input_feeder_stream.sv
// ---------------------------------------------------------------------------
// feeder_stream
// One memory-to-FIFO stream: walks row_len x num_rows addresses from base,
// keeps at most SKID_DEPTH words buffered or in flight, and pushes the skid
// head whenever the consumer is ready. With FLAGS set each word carries
// start-of-row / end-of-row bits above the data.
//   load       : latch base/lengths, clear counters (accepted start)
//   active     : reads may be issued (FSM in LOAD)
//   mem_*      : 1-cycle-latency read port
//   ready/w_en/push_data : consumer handshake
//   issued_all : every read of the job has been issued
//   idle       : nothing buffered and nothing in flight
// ---------------------------------------------------------------------------
module feeder_stream
  import pe_feeder_pkg::*;
#(
  parameter int   DW    = 16,
  parameter int   AW    = 10,
  parameter int   LEN_W = 8,
  parameter bit   FLAGS = 1'b1,
  localparam int  OW    = FLAGS ? DW + 2 : DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             active,
  input  logic [AW-1:0]    base,
  input  logic [LEN_W-1:0] row_len,
  input  logic [LEN_W-1:0] num_rows,
  output logic             mem_ren,
  output logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             ready,
  output logic             w_en,
  output logic [OW-1:0]    push_data,
  output logic             issued_all,
  output logic             idle
);

  logic [LEN_W-1:0] row_len_q, num_rows_q, col, row;
  logic [AW-1:0]    addr;
  logic             issued_all_q, in_flight, issue, pop;
  logic [OW-1:0]    skid [SKID_DEPTH];
  logic [OW-1:0]    entry;
  logic             rd_ptr, wr_ptr;
  logic [1:0]       count;
  logic [2:0]       occ_after_pop;

  // A word leaving this cycle frees its slot immediately, which is what lets
  // the stream sustain one word per cycle with only two slots.
  assign pop           = (count != 2'd0) && ready;
  assign occ_after_pop = {1'b0, count} + {2'b0, in_flight} - {2'b0, pop};
  assign issue         = active && !issued_all_q && (occ_after_pop < 3'(SKID_DEPTH));

  assign mem_ren    = issue;
  assign mem_addr   = addr;
  assign w_en       = pop;
  assign push_data  = (count != 2'd0) ? skid[rd_ptr] : '0;
  assign issued_all = issued_all_q;
  assign idle       = (count == 2'd0) && !in_flight;

  // Row/column walk; the address just increments since rows are contiguous
  always_ff @(posedge clk) begin
    if (rst) begin
      addr         <= '0;
      col          <= '0;
      row          <= '0;
      row_len_q    <= '0;
      num_rows_q   <= '0;
      issued_all_q <= 1'b0;
    end else if (load) begin
      addr         <= base;
      col          <= '0;
      row          <= '0;
      row_len_q    <= row_len;
      num_rows_q   <= num_rows;
      issued_all_q <= (row_len == '0) || (num_rows == '0);
    end else if (issue) begin
      addr <= addr + 1'b1;
      if (col == row_len_q - 1'b1) begin
        col <= '0;
        row <= row + 1'b1;
        if (row == num_rows_q - 1'b1) issued_all_q <= 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Clearing in_flight on reset is what drops data returning after an abort
  always_ff @(posedge clk) begin
    if (rst) in_flight <= 1'b0;
    else     in_flight <= issue;
  end

  // Flags are decided at issue time and travel with the read
  generate
    if (FLAGS) begin : g_flags
      logic sor_q, eor_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          sor_q <= 1'b0;
          eor_q <= 1'b0;
        end else if (issue) begin
          sor_q <= (col == '0);
          eor_q <= (col == row_len_q - 1'b1);
        end
      end
      always_comb begin
        entry              = '0;
        entry[DW-1:0]      = mem_rdata;
        entry[DW+EOR_BIT]  = eor_q;
        entry[DW+SOR_BIT]  = sor_q;
      end
    end else begin : g_noflags
      assign entry = mem_rdata;
    end
  endgenerate

  // Skid pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (in_flight) wr_ptr <= ~wr_ptr;
      if (pop)       rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, in_flight} - {1'b0, pop};
    end
  end

  // Skid storage needs no reset; it is only read while occupied
  always_ff @(posedge clk) begin
    if (in_flight) skid[wr_ptr] <= entry;
  end

endmodule

// File: rtl/pe_input_feeder.sv
// ---------------------------------------------------------------------------
// pe_input_feeder
// Fetches ifmap and filter words from two read memories and pushes them into
// the PE input FIFOs. Both streams run concurrently; done pulses once both
// have issued every read and fully drained.
//   clk, rst          : clock, synchronous active-high reset
//   start             : job request, only taken in IDLE
//   ifm_base/fil_base : first word addresses
//   row_len/num_rows  : ifmap job shape;  fil_len : filter word count
//   mem_ifm_*/mem_fil_* : read ports, data one cycle after ren
//   pe                : push bus to the PE FIFOs (master side)
//   busy              : job accepted and not yet complete
//   done              : one-cycle completion pulse
// ---------------------------------------------------------------------------
module pe_input_feeder
  import pe_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_WRITE  = 2,
  parameter int IFM_MEM_AW = 10,
  parameter int FIL_MEM_AW = 8,
  parameter int LEN_W      = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [IFM_MEM_AW-1:0]            ifm_base,
  input  logic [FIL_MEM_AW-1:0]            fil_base,
  input  logic [LEN_W-1:0]                 row_len,
  input  logic [LEN_W-1:0]                 num_rows,
  input  logic [LEN_W-1:0]                 fil_len,
  output logic                             mem_ifm_ren,
  output logic [IFM_MEM_AW-1:0]            mem_ifm_addr,
  input  logic [DATA_WIDTH*PAR_WRITE-1:0]  mem_ifm_rdata,
  output logic                             mem_fil_ren,
  output logic [FIL_MEM_AW-1:0]            mem_fil_addr,
  input  logic [DATA_WIDTH*PAR_WRITE-1:0]  mem_fil_rdata,
  pe_input_feeder_if.master                pe,
  output logic                             busy,
  output logic                             done
);

  localparam int WW = DATA_WIDTH * PAR_WRITE;

  state_t state, state_nx;
  logic   start_ok, active;
  logic   ifm_issued_all, fil_issued_all, ifm_idle, fil_idle;

  assign start_ok = (state == IDLE) && start;
  assign active   = (state == LOAD);
  assign busy     = (state == LOAD) || (state == DRAIN);
  assign done     = (state == DONE);

  // Job sequencing: issue reads, wait for both skids to empty, pulse done
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (ifm_issued_all && fil_issued_all) state_nx = DRAIN;
      DRAIN:   if (ifm_idle && fil_idle) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  feeder_stream #(
    .DW(WW), .AW(IFM_MEM_AW), .LEN_W(LEN_W), .FLAGS(1'b1)
  ) u_ifm (
    .clk(clk), .rst(rst), .load(start_ok), .active(active),
    .base(ifm_base), .row_len(row_len), .num_rows(num_rows),
    .mem_ren(mem_ifm_ren), .mem_addr(mem_ifm_addr), .mem_rdata(mem_ifm_rdata),
    .ready(pe.ready_ifm), .w_en(pe.w_en_ifm), .push_data(pe.data_in_ifm),
    .issued_all(ifm_issued_all), .idle(ifm_idle)
  );

  // The filter is a single "row" of fil_len words with no flags
  feeder_stream #(
    .DW(WW), .AW(FIL_MEM_AW), .LEN_W(LEN_W), .FLAGS(1'b0)
  ) u_fil (
    .clk(clk), .rst(rst), .load(start_ok), .active(active),
    .base(fil_base), .row_len(fil_len), .num_rows(LEN_W'(1)),
    .mem_ren(mem_fil_ren), .mem_addr(mem_fil_addr), .mem_rdata(mem_fil_rdata),
    .ready(pe.ready_fil), .w_en(pe.w_en_fil), .push_data(pe.data_in_fil),
    .issued_all(fil_issued_all), .idle(fil_idle)
  );

endmodule

// File: tb/tb_pe_input_feeder.sv
// ---------------------------------------------------------------------------
// tb_pe_input_feeder
// Scoreboard bench: each job's expected read addresses and pushed words are
// built from the row/column description and queued; a monitor on the falling
// edge pops and compares whenever the DUT reads or pushes.
// ---------------------------------------------------------------------------
module tb_pe_input_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  ifm_base = '0;
  logic [7:0]  fil_base = '0;
  logic [7:0]  row_len = '0, num_rows = '0, fil_len = '0;
  logic        mem_ifm_ren, mem_fil_ren;
  logic [9:0]  mem_ifm_addr;
  logic [7:0]  mem_fil_addr;
  logic [15:0] mem_ifm_rdata = '0, mem_fil_rdata = '0;
  logic        ready_ifm = 1'b1, ready_fil = 1'b1;
  logic        busy, done;

  logic [15:0] ifm_mem [1024];
  logic [15:0] fil_mem [256];

  logic [17:0] exp_ifm [$];
  logic [15:0] exp_fil [$];
  logic [9:0]  exp_ifm_addr [$];
  logic [7:0]  exp_fil_addr [$];

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  bit mon_en = 1'b1;
  bit bp = 1'b0;
  int ifm_pushes, ifm_first, ifm_last, fil_pushes, fil_first, fil_last, done_cnt;

  pe_input_feeder_if #(.DATA_WIDTH(8), .PAR_WRITE(2)) pe_bus ();
  assign pe_bus.ready_ifm = ready_ifm;
  assign pe_bus.ready_fil = ready_fil;

  pe_input_feeder dut (
    .clk(clk), .rst(rst), .start(start),
    .ifm_base(ifm_base), .fil_base(fil_base),
    .row_len(row_len), .num_rows(num_rows), .fil_len(fil_len),
    .mem_ifm_ren(mem_ifm_ren), .mem_ifm_addr(mem_ifm_addr), .mem_ifm_rdata(mem_ifm_rdata),
    .mem_fil_ren(mem_fil_ren), .mem_fil_addr(mem_fil_addr), .mem_fil_rdata(mem_fil_rdata),
    .pe(pe_bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Memories with one cycle of read latency
  always @(posedge clk) begin
    if (mem_ifm_ren) mem_ifm_rdata <= ifm_mem[mem_ifm_addr];
    if (mem_fil_ren) mem_fil_rdata <= fil_mem[mem_fil_addr];
  end

  // Consumer readiness: always ready, or a 50% coin per cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp) begin
        ready_ifm = 1'($urandom_range(0, 1));
        ready_fil = 1'($urandom_range(0, 1));
      end else begin
        ready_ifm = 1'b1;
        ready_fil = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: compare every read address and every pushed word
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (mem_ifm_ren) begin
        if (exp_ifm_addr.size() == 0) fail_now("ifm_ren_extra");
        else check("ifm_addr", 64'(mem_ifm_addr), 64'(exp_ifm_addr.pop_front()));
      end
      if (mem_fil_ren) begin
        if (exp_fil_addr.size() == 0) fail_now("fil_ren_extra");
        else check("fil_addr", 64'(mem_fil_addr), 64'(exp_fil_addr.pop_front()));
      end
      if (pe_bus.w_en_ifm) begin
        check("ifm_wen_ready", 64'(ready_ifm), 64'(1));
        if (exp_ifm.size() == 0) fail_now("ifm_push_extra");
        else check("ifm_word", 64'(pe_bus.data_in_ifm), 64'(exp_ifm.pop_front()));
        if (ifm_first < 0) ifm_first = cyc;
        ifm_last = cyc;
        ifm_pushes++;
      end
      if (pe_bus.w_en_fil) begin
        check("fil_wen_ready", 64'(ready_fil), 64'(1));
        if (exp_fil.size() == 0) fail_now("fil_push_extra");
        else check("fil_word", 64'(pe_bus.data_in_fil), 64'(exp_fil.pop_front()));
        if (fil_first < 0) fil_first = cyc;
        fil_last = cyc;
        fil_pushes++;
      end
      if (done) done_cnt++;
    end
  end

  // Expected traffic straight from the job description
  task automatic build_expect(input logic [9:0] ib, input logic [7:0] fb,
                              input int rl, input int nr, input int fl);
    exp_ifm.delete(); exp_fil.delete(); exp_ifm_addr.delete(); exp_fil_addr.delete();
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < rl; c++) begin
        logic [9:0] a;
        a = 10'((int'(ib) + r * rl + c) % 1024);
        exp_ifm_addr.push_back(a);
        exp_ifm.push_back({(c == 0), (c == rl - 1), ifm_mem[a]});
      end
    end
    for (int i = 0; i < fl; i++) begin
      logic [7:0] a;
      a = 8'((int'(fb) + i) % 256);
      exp_fil_addr.push_back(a);
      exp_fil.push_back(fil_mem[a]);
    end
    ifm_pushes = 0; fil_pushes = 0; done_cnt = 0;
    ifm_first = -1; fil_first = -1; ifm_last = -1; fil_last = -1;
  endtask

  task automatic launch(input logic [9:0] ib, input logic [7:0] fb,
                        input int rl, input int nr, input int fl, output int s);
    @(posedge clk);
    #1;
    ifm_base = ib; fil_base = fb;
    row_len = 8'(rl); num_rows = 8'(nr); fil_len = 8'(fl);
    start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_case(input logic [9:0] ib, input logic [7:0] fb,
                          input int rl, input int nr, input int fl, input bit bpm);
    int  s, d, n_ifm;
    bit  got, prev_busy;
    n_ifm = rl * nr;
    build_expect(ib, fb, rl, nr, fl);
    bp = bpm;
    launch(ib, fb, rl, nr, fl, s);
    got = 1'b0; prev_busy = 1'b0; d = 0;
    for (int g = 0; g < 3000; g++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        d = cyc;
        break;
      end
      prev_busy = busy;
      // A second start while busy must be ignored
      if (g == 0) start = 1'b1;
      if (g == 1) start = 1'b0;
    end
    start = 1'b0;
    check("done_seen", 64'(got), 64'(1));
    if (got) begin
      check("busy_before_done", 64'(prev_busy), 64'(1));
      check("busy_at_done", 64'(busy), 64'(0));
      if ((n_ifm == 0) && (fl == 0)) check("done_latency", 64'(d - s), 64'(3));
      if (n_ifm > 0) check("done_after_ifm", 64'(d > ifm_last), 64'(1));
      if (fl > 0)    check("done_after_fil", 64'(d > fil_last), 64'(1));
    end
    check("ifm_words_left", 64'(exp_ifm.size()), 64'(0));
    check("fil_words_left", 64'(exp_fil.size()), 64'(0));
    check("ifm_reads_left", 64'(exp_ifm_addr.size()), 64'(0));
    check("fil_reads_left", 64'(exp_fil_addr.size()), 64'(0));
    if (!bpm && n_ifm > 0) check("ifm_throughput", 64'(ifm_last - ifm_first), 64'(n_ifm - 1));
    if (!bpm && fl > 0)    check("fil_throughput", 64'(fil_last - fil_first), 64'(fl - 1));
    bp = 1'b0;
    repeat (4) @(negedge clk);
    check("done_once", 64'(done_cnt), 64'(1));
    check("idle_after", 64'(busy), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_ifm_ren"}, 64'(mem_ifm_ren), 64'(0));
    check({tag, "_fil_ren"}, 64'(mem_fil_ren), 64'(0));
    check({tag, "_ifm_addr"}, 64'(mem_ifm_addr), 64'(0));
    check({tag, "_fil_addr"}, 64'(mem_fil_addr), 64'(0));
    check({tag, "_ifm_wen"}, 64'(pe_bus.w_en_ifm), 64'(0));
    check({tag, "_fil_wen"}, 64'(pe_bus.w_en_fil), 64'(0));
    check({tag, "_ifm_data"}, 64'(pe_bus.data_in_ifm), 64'(0));
    check({tag, "_fil_data"}, 64'(pe_bus.data_in_fil), 64'(0));
  endtask

  initial begin
    int s;
    bit reached;
    // Distinct contents so any address slip shows up as a data error
    for (int i = 0; i < 1024; i++) ifm_mem[i] = {6'($urandom), 10'(i)};
    for (int i = 0; i < 256; i++)  fil_mem[i] = {8'($urandom), 8'(i)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] basic");
    run_case(10'd100, 8'd10, 4, 2, 3, 1'b0);
    $display("[TB] back-pressure");
    run_case(10'd100, 8'd10, 4, 2, 3, 1'b1);
    $display("[TB] single-word rows");
    run_case(10'd37, 8'd200, 1, 3, 2, 1'b0);
    $display("[TB] zero lengths");
    run_case(10'd5, 8'd5, 0, 2, 0, 1'b0);
    $display("[TB] address wrap");
    run_case(10'd1022, 8'd254, 4, 1, 4, 1'b0);
    $display("[TB] random jobs");
    for (int k = 0; k < 6; k++) begin
      run_case(10'($urandom), 8'($urandom), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
               1'($urandom_range(0, 1)));
    end

    $display("[TB] mid-run reset");
    build_expect(10'd300, 8'd40, 4, 2, 3);
    launch(10'd300, 8'd40, 4, 2, 3, s);
    reached = 1'b0;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (ifm_pushes >= 3) begin
        reached = 1'b1;
        break;
      end
    end
    check("reset_reach_3_pushes", 64'(reached), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    @(negedge clk);
    check("abort_late_data_ifm", 64'(pe_bus.w_en_ifm), 64'(0));
    check("abort_late_data_fil", 64'(pe_bus.w_en_fil), 64'(0));
    mon_en = 1'b1;
    run_case(10'd300, 8'd40, 4, 2, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
